// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : RV32 memory stage with single-outstanding req/ack bus
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.  Rev 1.0
// ============================================================================
module load_store_unit #(
    parameter int X_LENGTH        = 32,
    parameter int REG_INDEX_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_op_load,
    input  logic                       in_op_store,
    input  logic [2:0]                 in_funct3,
    input  logic [X_LENGTH-1:0]        in_alu_result,
    input  logic [X_LENGTH-1:0]        in_store_data,
    input  logic [REG_INDEX_WIDTH-1:0] in_rd_index,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [X_LENGTH-1:0]        mem_addr,
    output logic [3:0]                 mem_wstrb,
    output logic [X_LENGTH-1:0]        mem_wdata,
    input  logic                       mem_ack,
    input  logic [X_LENGTH-1:0]        mem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REG_INDEX_WIDTH-1:0] out_rd_index,
    output logic [X_LENGTH-1:0]        out_data,
    output logic                       out_write_enable,
    output logic                       out_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                       w_accept;
    logic                       w_is_mem;
    logic                       w_is_store;
    logic                       w_trap;
    logic [1:0]                 w_size;
    logic [1:0]                 w_off;
    logic [3:0]                 w_strb;
    logic [X_LENGTH-1:0]        w_wdata;
    logic [X_LENGTH-1:0]        w_lane;
    logic [X_LENGTH-1:0]        w_load_data;

    logic [1:0]                 r_off;
    logic [2:0]                 r_funct3;
    logic [REG_INDEX_WIDTH-1:0] r_rd;
    logic [X_LENGTH-1:0]        r_out_data;
    logic                       r_out_we;
    logic                       r_fault;
    logic [X_LENGTH-1:0]        r_mem_addr;
    logic                       r_mem_we;
    logic [3:0]                 r_mem_wstrb;
    logic [X_LENGTH-1:0]        r_mem_wdata;

    assign in_ready   = (r_state == IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_is_mem   = in_op_load || in_op_store;
    assign w_is_store = in_op_store && !in_op_load;
    assign w_size     = in_funct3[1:0];

    // Byte offset actually used: halves drop a[0], words always use lane 0.
    always_comb begin
        w_off = 2'b00;
        case (w_size)
            2'b00:   w_off = in_alu_result[1:0];
            2'b01:   w_off = {in_alu_result[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ((w_size == 2'b01) && in_alu_result[0]) ||
                          (w_size[1] && (in_alu_result[1:0] != 2'b00));
    assign w_trap       = w_is_mem && w_misaligned;
`else
    assign w_trap       = 1'b0;
`endif

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = in_store_data;
        case (w_size)
            2'b00: begin
                w_strb  = 4'b0001 << w_off;
                w_wdata = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << w_off;
                w_wdata = {2{in_store_data[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = in_store_data;
            end
        endcase
    end

    assign w_lane = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_lane;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load_data = {24'd0, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_load_data = {16'd0, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_trap)        w_next_state = RESP;
                    else if (w_is_mem) w_next_state = BUS;
                    else               w_next_state = RESP;
                end
            end
            BUS:     if (mem_ack)   w_next_state = RESP;
            RESP:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_off       <= 2'b00;
            r_funct3    <= 3'b000;
            r_rd        <= '0;
            r_out_data  <= '0;
            r_out_we    <= 1'b0;
            r_fault     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_off    <= w_off;
            r_funct3 <= in_funct3;
            r_rd     <= in_rd_index;
            if (w_trap) begin
                r_out_data <= in_alu_result;
                r_out_we   <= 1'b0;
                r_fault    <= 1'b1;
            end else if (w_is_mem) begin
                r_mem_addr  <= {in_alu_result[X_LENGTH-1:2], 2'b00};
                r_mem_we    <= w_is_store;
                r_mem_wstrb <= w_is_store ? w_strb : 4'b0000;
                r_mem_wdata <= w_is_store ? w_wdata : '0;
                r_out_data  <= '0;
                r_out_we    <= !w_is_store && (in_rd_index != '0);
                r_fault     <= 1'b0;
            end else begin
                r_out_data <= in_alu_result;
                r_out_we   <= (in_rd_index != '0);
                r_fault    <= 1'b0;
            end
        end else if ((r_state == BUS) && mem_ack && !r_mem_we) begin
            r_out_data <= w_load_data;
        end
    end

    assign mem_req          = (r_state == BUS);
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_wstrb        = r_mem_wstrb;
    assign mem_wdata        = r_mem_wdata;
    assign out_valid        = (r_state == RESP);
    assign out_rd_index     = r_rd;
    assign out_data         = r_out_data;
    assign out_write_enable = r_out_we;
    assign out_fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed vectors with hand-computed expectations
// Rev 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op_load;
    logic        in_op_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd_index;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_index;
    logic [31:0] out_data;
    logic        out_write_enable;
    logic        out_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.X_LENGTH(32), .REG_INDEX_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_load(in_op_load), .in_op_store(in_op_store),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_rd_index(in_rd_index),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_index(out_rd_index), .out_data(out_data),
        .out_write_enable(out_write_enable), .out_fault(out_fault)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
        in_valid      = 1'b1;
        in_op_load    = ld;
        in_op_store   = st;
        in_funct3     = f3;
        in_alu_result = a;
        in_store_data = sd;
        in_rd_index   = rd;
        @(negedge clk);
        in_valid    = 1'b0;
        in_op_load  = 1'b0;
        in_op_store = 1'b0;
    endtask

    task automatic ack_bus(input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Response is consumed with out_ready=1; returns at the negedge back in IDLE.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op_load = 1'b0; in_op_store = 1'b0;
        in_funct3 = 3'b000; in_alu_result = 32'h0; in_store_data = 32'h0;
        in_rd_index = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_out_fault", {31'd0, out_fault}, 32'd0);
        rst = 1'b0;
        #1;
        check_val("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Pass-through
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        check_val("pt_valid", {31'd0, out_valid}, 32'd1);
        check_val("pt_data", out_data, 32'h0000_1234);
        check_val("pt_we", {31'd0, out_write_enable}, 32'd1);
        check_val("pt_rd", {27'd0, out_rd_index}, 32'd5);
        check_val("pt_req", {31'd0, mem_req}, 32'd0);
        check_val("pt_in_ready", {31'd0, in_ready}, 32'd0);
        drain("pt");

        // LB 0x1003 with three wait cycles, then LBU with same stimulus
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h0000_1003, 32'h0, 5'd6);
            for (int w = 0; w < 4; w++) begin
                check_val("lb_req", {31'd0, mem_req}, 32'd1);
                check_val("lb_addr", mem_addr, 32'h0000_1000);
                check_val("lb_we", {31'd0, mem_we}, 32'd0);
                check_val("lb_strb", {28'd0, mem_wstrb}, 32'd0);
                if (w < 3) @(negedge clk);
            end
            ack_bus(32'h80FF_FF7F);
            check_val("lb_valid", {31'd0, out_valid}, 32'd1);
            check_val("lb_req_drop", {31'd0, mem_req}, 32'd0);
            check_val("lb_data", out_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            check_val("lb_we_rf", {31'd0, out_write_enable}, 32'd1);
            drain("lb");
        end

        // SH 0x2002, zero-wait bus
        issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd7);
        check_val("sh_req", {31'd0, mem_req}, 32'd1);
        check_val("sh_we", {31'd0, mem_we}, 32'd1);
        check_val("sh_addr", mem_addr, 32'h0000_2000);
        check_val("sh_strb", {28'd0, mem_wstrb}, 32'hC);
        check_val("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        ack_bus(32'h1111_1111);
        check_val("sh_valid", {31'd0, out_valid}, 32'd1);
        check_val("sh_rf_we", {31'd0, out_write_enable}, 32'd0);
        check_val("sh_data", out_data, 32'd0);
        drain("sh");

        // SB 0x2003
        issue(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 5'd1);
        check_val("sb_strb", {28'd0, mem_wstrb}, 32'h8);
        check_val("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        ack_bus(32'h0);
        drain("sb");

        // Backpressure on a completed LW while a new request waits
        out_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd3);
        ack_bus(32'h1234_5678);
        in_valid = 1'b1; in_op_load = 1'b1; in_funct3 = 3'b010;
        in_alu_result = 32'h0000_4444; in_rd_index = 5'd4;
        for (int c = 0; c < 5; c++) begin
            check_val("bp_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_data", out_data, 32'h1234_5678);
            check_val("bp_rd", {27'd0, out_rd_index}, 32'd3);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("bp_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_op_load = 1'b0;
        drain("bp");

        // Asynchronous reset mid-transaction
        issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd8);
        check_val("mr_req_before", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1 check_val("mr_req_async", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_bus(32'hFFFF_FFFF);
        check_val("mr_late_ack_valid", {31'd0, out_valid}, 32'd0);
        check_val("mr_late_ack_req", {31'd0, mem_req}, 32'd0);
        check_val("mr_in_ready", {31'd0, in_ready}, 32'd1);

        // Following load with rd=0 still reads the bus
        issue(1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'h0, 5'd0);
        check_val("lh_req", {31'd0, mem_req}, 32'd1);
        check_val("lh_addr", mem_addr, 32'h0000_6000);
        ack_bus(32'h8001_1234);
        check_val("lh_data", out_data, 32'hFFFF_8001);
        check_val("lh_rf_we", {31'd0, out_write_enable}, 32'd0);
        drain("lh");

        // Misaligned LW at 0x3001
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd9);
`ifdef LSU_MISALIGN_TRAP_EN
        check_val("mis_req", {31'd0, mem_req}, 32'd0);
        check_val("mis_valid", {31'd0, out_valid}, 32'd1);
        check_val("mis_fault", {31'd0, out_fault}, 32'd1);
        check_val("mis_data", out_data, 32'h0000_3001);
        check_val("mis_rf_we", {31'd0, out_write_enable}, 32'd0);
`else
        check_val("mis_req", {31'd0, mem_req}, 32'd1);
        check_val("mis_addr", mem_addr, 32'h0000_3000);
        ack_bus(32'hCAFE_F00D);
        check_val("mis_data", out_data, 32'hCAFE_F00D);
        check_val("mis_fault", {31'd0, out_fault}, 32'd0);
        check_val("mis_rf_we", {31'd0, out_write_enable}, 32'd1);
`endif
        drain("mis");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU in the RV32 core.
- Consumes the ALU result: it is the effective address for loads and stores, or plain writeback data for all other instructions.
- Drives a simple single-outstanding req/ack data bus, aligns and extends load data, and forms store strobes and data.
- Hands results to writeback through a valid/ready handshake.

Parameters:
X_LENGTH, 32, datapath and address width (RV32 only; the bus is 32-bit word-addressed with byte strobes)
REG_INDEX_WIDTH, 5, destination register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  execute stage presents an instruction
in_ready  output  1  unit can accept; equals (state==IDLE)
in_op_load  input  1  instruction is a load
in_op_store  input  1  instruction is a store
in_funct3  input  3  width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_alu_result  input  X_LENGTH  ALU result (address or writeback value)
in_store_data  input  X_LENGTH  rs2 value for stores
in_rd_index  input  REG_INDEX_WIDTH  destination register
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  X_LENGTH  word address, bits [1:0] always 0
mem_wstrb  output  4  byte-lane write strobes
mem_wdata  output  X_LENGTH  lane-replicated store data
mem_ack  input  1  bus completes the current request this cycle
mem_rdata  input  X_LENGTH  read word, valid when mem_ack
out_valid  output  1  result for writeback available
out_ready  input  1  writeback accepts
out_rd_index  output  REG_INDEX_WIDTH  destination register
out_data  output  X_LENGTH  writeback value
out_write_enable  output  1  register file write required
out_fault  output  1  misaligned access (see Optional Feature)

Behaviour:
- Reset:
  - Asynchronous on rst high; state IDLE.
  - All outputs 0, except in_ready = 1 once rst is low.
  - Reset mid-transaction drops mem_req immediately and abandons the access; a late mem_ack is ignored.
- Accept: handshake when in_valid && in_ready. Inputs are captured into registers; nothing is combinationally forwarded to outputs.
- FSM states:
  - IDLE: on accept:
    - load or store, aligned: go to BUS.
    - neither: go to RESP.
    - both set: treated as load.
  - BUS: mem_req = 1. mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_ack. On mem_ack, capture data and go to RESP.
  - RESP: out_valid = 1, all out_* stable until out_ready. On out_ready, go to IDLE.
- Latency:
  - Pass-through: out_valid the cycle after accept.
  - Memory: mem_req the cycle after accept; out_valid the cycle after mem_ack.
  - Zero-wait bus: out_valid 2 cycles after accept.
  - Throughput is at most one instruction per 2 cycles (no overlap).
- mem_ack outside BUS is ignored.
- Pass-through:
  - out_data = alu_result.
  - out_write_enable = (rd != 0).
- Store:
  - Size from funct3[1:0]; 11 is treated as word.
  - SB: wstrb = 0001 << a[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 0011 << a[1:0]; wdata = half replicated ×2.
  - SW: wstrb = 1111.
  - Writeback side: out_write_enable = 0, out_data = 0.
- Load:
  - mem_wstrb = 0.
  - Lane = mem_rdata >> (8 × a[1:0]), then:
    - B: sign-extend bits [7:0].
    - BU: zero-extend bits [7:0].
    - H: sign-extend bits [15:0].
    - HU: zero-extend bits [15:0].
    - W and funct3 011/110/111: full word.
  - out_write_enable = (rd != 0); rd = 0 still performs the bus read.
- mem_addr = {a[31:2], 2'b00}.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with a[0] = 1, or a word access with a[1:0] != 0, issues no bus request.
  - Goes IDLE to RESP with out_fault = 1, out_write_enable = 0, out_data = faulting address.
- Undefined:
  - out_fault is tied to 0.
  - Misaligned accesses are forced aligned: the half access uses a[1] with a[0] treated as 0; the word access uses lane 0.

Test Plan:
- Pass-through: accept alu_result = 0x0000_1234, rd = 5, out_ready = 1 -> next cycle out_valid = 1, out_data = 0x1234, out_write_enable = 1, mem_req never asserted.
- LB, address 0x1003, mem_rdata = 0x80FF_FF7F, ack after 3 wait cycles -> mem_addr = 0x1000 held stable for 4 cycles; out_data = 0xFFFF_FF80. Same stimulus with LBU -> out_data = 0x0000_0080.
- SH, address 0x2002, store_data = 0xDEAD_BEEF -> mem_we = 1, wstrb = 1100, wdata = 0xBEEF_BEEF, out_write_enable = 0.
- Backpressure: load completes while out_ready = 0 for 5 cycles -> out_* stable, in_ready = 0, no new mem_req; out_ready = 1 -> IDLE next cycle.
- rst pulsed high while mem_req = 1 -> mem_req = 0 immediately; a later mem_ack has no effect; next load completes normally.
- Misaligned LW at 0x3001:
  - With LSU_MISALIGN_TRAP_EN: no mem_req, out_fault = 1, out_data = 0x3001.
  - Without it: mem_addr = 0x3000, full word returned.
